prog_sequencer: RTL and testbench

- Top-level run controller for the single-cycle core.
- Selects which of the three resident programs (PRODUCT, STRING MATCH, CLOSEST PAIR) executes and forces the program counter to that program's start address.
- Gates execution, detects program completion via the decoded HALT op, and reports done and a cycle count to the testbench over a start/ack handshake.
- Sits between the testbench and the pc/control blocks; replaces reset-toggling as the program-select mechanism.

---
 rtl/prog_sequencer_pkg.sv | 31 +++
 rtl/prog_sequencer_if.sv | 24 ++
 rtl/prog_sequencer_sat_counter.sv | 26 ++
 rtl/prog_sequencer.sv | 123 ++++++++++++
 tb/tb_prog_sequencer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/prog_sequencer_pkg.sv
// Shared types and constants for the program run controller.
// Start addresses must match the assembler's label map.
package prog_sequencer_pkg;

  localparam int unsigned SEQ_CNT_W = 16;
  localparam int unsigned ADDR_W    = 8;

  localparam logic [ADDR_W-1:0]    START_PROD  = 8'd0;
  localparam logic [ADDR_W-1:0]    START_STRM  = 8'd28;
  localparam logic [ADDR_W-1:0]    START_CPAIR = 8'd48;
  localparam logic [SEQ_CNT_W-1:0] SEQ_TIMEOUT = 16'd4000;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} seq_state_t;

  typedef enum logic [1:0] {
    PROD  = 2'd0,
    STRM  = 2'd1,
    CPAIR = 2'd2,
    NEXT  = 2'd3
  } prog_t;

  // Round-robin successor over the three resident programs.
  function automatic prog_t next_prog(prog_t last);
    return (last == CPAIR) ? PROD : prog_t'(2'(last + 2'd1));
  endfunction

  function automatic prog_t resolve_prog(logic [1:0] sel, prog_t last);
    return (sel == 2'(NEXT)) ? next_prog(last) : prog_t'(sel);
  endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// Testbench-facing start/ack handshake and run report of the sequencer.
interface prog_sequencer_if #(
  parameter int unsigned CNT_W = prog_sequencer_pkg::SEQ_CNT_W
) ();

  logic             start;
  logic [1:0]       start_sel;
  logic             ack;
  logic             done;
  logic             timeout;
  logic [1:0]       prog_id;
  logic [CNT_W-1:0] cycles;

  modport master (
    output start, start_sel, ack,
    input  done, timeout, prog_id, cycles
  );

  modport slave (
    input  start, start_sel, ack,
    output done, timeout, prog_id, cycles
  );

endinterface

// File: rtl/prog_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear and terminal-count compare.
module prog_sequencer_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] tc_val,
  output logic [W-1:0] count,
  output logic         tc_hit_c
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

  assign tc_hit_c = (count == tc_val);

endmodule

// File: rtl/prog_sequencer.sv
// Run controller: selects a resident program, loads its start PC, gates the
// core while it runs and reports halt/timeout completion over start/ack.
module prog_sequencer
  import prog_sequencer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] START0  = START_PROD,
  parameter logic [ADDR_W-1:0] START1  = START_STRM,
  parameter logic [ADDR_W-1:0] START2  = START_CPAIR,
  parameter int unsigned       CNT_W   = SEQ_CNT_W,
  parameter logic [CNT_W-1:0]  TIMEOUT = CNT_W'(SEQ_TIMEOUT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halt,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_target,
  output logic              run,
  prog_sequencer_if.slave   bus
);

  seq_state_t        state_q, state_d;
  prog_t             prog_id_q, prog_id_d;
  logic [ADDR_W-1:0] pc_target_d;
  logic              pc_load_d, run_d, done_q, done_d, timeout_q, timeout_d;
  logic              cnt_clr, cnt_en, cnt_tc;
  logic [CNT_W-1:0]  cycles;

  function automatic logic [ADDR_W-1:0] start_addr(prog_t p);
    case (p)
      PROD:    return START0;
      STRM:    return START1;
      default: return START2;
    endcase
  endfunction

  // Outputs are computed for the state being entered, then registered.
  always_comb begin
    state_d     = state_q;
    prog_id_d   = prog_id_q;
    pc_target_d = pc_target;
    pc_load_d   = 1'b0;
    run_d       = 1'b0;
    done_d      = 1'b0;
    timeout_d   = timeout_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          prog_id_d   = resolve_prog(bus.start_sel, prog_id_q);
          pc_target_d = start_addr(prog_id_d);
          pc_load_d   = 1'b1;
          timeout_d   = 1'b0;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        cnt_clr = 1'b1;
        run_d   = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        cnt_en = 1'b1;
        if (halt) begin
          done_d    = 1'b1;
          timeout_d = 1'b0;
          state_d   = DONE;
        end else if (cnt_tc) begin
          done_d    = 1'b1;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          run_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.ack) begin
          state_d = IDLE;
        end else begin
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      prog_id_q <= CPAIR;
      pc_target <= START0;
      pc_load   <= 1'b0;
      run       <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prog_id_q <= prog_id_d;
      pc_target <= pc_target_d;
      pc_load   <= pc_load_d;
      run       <= run_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  // Terminal count is TIMEOUT-1 so the aborting cycle reports exactly TIMEOUT.
  prog_sequencer_sat_counter #(.W(CNT_W)) u_cycles (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .tc_val   (TIMEOUT - CNT_W'(1)),
    .count    (cycles),
    .tc_hit_c (cnt_tc)
  );

  assign bus.done    = done_q;
  assign bus.timeout = timeout_q;
  assign bus.prog_id = prog_id_q;
  assign bus.cycles  = cycles;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed plus randomized check of prog_sequencer against a run-level model.
module tb_prog_sequencer;

  localparam int TMO = 4000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       halt = 1'b0;
  logic       pc_load;
  logic [7:0] pc_target;
  logic       run;

  prog_sequencer_if bus ();

  prog_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .halt      (halt),
    .pc_load   (pc_load),
    .pc_target (pc_target),
    .run       (run),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int last_prog = 2;
  int tab [3] = '{0, 28, 48};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One complete program run: start, optional stray start in RUN, halt on
  // RUN cycle nhalt (0 = never), hold DONE for 'hold' cycles, then ack.
  task automatic do_run(input int sel, input int nhalt, input bit pulse,
                        input int hold, input bit ack_start);
    int prog, exp_cyc, k;
    bit exp_to;
    prog = (sel == 3) ? (last_prog + 1) % 3 : sel;
    if (nhalt >= 1 && nhalt <= TMO) begin
      exp_cyc = nhalt;
      exp_to  = 1'b0;
    end else begin
      exp_cyc = TMO;
      exp_to  = 1'b1;
    end
    chk("idle_run", 32'(run), 0);
    bus.start = 1'b1;
    bus.start_sel = 2'(sel);
    tick();
    bus.start = 1'b0;
    chk("load_pc_load", 32'(pc_load), 1);
    chk("load_pc_target", 32'(pc_target), 32'(tab[prog]));
    chk("load_prog_id", 32'(bus.prog_id), 32'(prog));
    chk("load_run", 32'(run), 0);
    tick();
    chk("run_first", 32'(run), 1);
    chk("run_cycles0", 32'(bus.cycles), 0);
    k = 1;
    while (!bus.done && k <= TMO + 10) begin
      if (k == nhalt) halt = 1'b1;
      if (pulse && k == 2) begin
        bus.start = 1'b1;
        bus.start_sel = 2'((prog + 1) % 3);
      end
      tick();
      halt = 1'b0;
      if (pulse && k == 2) begin
        bus.start = 1'b0;
        chk("stray_start_pc_load", 32'(pc_load), 0);
        chk("stray_start_prog_id", 32'(bus.prog_id), 32'(prog));
      end
      k++;
    end
    chk("done", 32'(bus.done), 1);
    chk("done_timeout", 32'(bus.timeout), 32'(exp_to));
    chk("done_cycles", 32'(bus.cycles), 32'(exp_cyc));
    chk("done_run", 32'(run), 0);
    chk("done_prog_id", 32'(bus.prog_id), 32'(prog));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_done", 32'(bus.done), 1);
      chk("hold_cycles", 32'(bus.cycles), 32'(exp_cyc));
    end
    bus.ack = 1'b1;
    if (ack_start) bus.start = 1'b1;
    tick();
    bus.ack = 1'b0;
    bus.start = 1'b0;
    chk("ack_done", 32'(bus.done), 0);
    chk("ack_timeout_kept", 32'(bus.timeout), 32'(exp_to));
    chk("ack_pc_load", 32'(pc_load), 0);
    if (ack_start) begin
      tick();
      chk("ack_start_no_load", 32'(pc_load), 0);
      chk("ack_start_run", 32'(run), 0);
    end
    last_prog = prog;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc_load"}, 32'(pc_load), 0);
    chk({tag, "_pc_target"}, 32'(pc_target), 0);
    chk({tag, "_run"}, 32'(run), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_timeout"}, 32'(bus.timeout), 0);
    chk({tag, "_prog_id"}, 32'(bus.prog_id), 2);
    chk({tag, "_cycles"}, 32'(bus.cycles), 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.start_sel = 2'd0;
    bus.ack = 1'b0;
    repeat (3) tick();
    chk_reset_vals("por");
    reset = 1'b1;
    tick();

    // Halt while idle has no effect.
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("idle_halt_done", 32'(bus.done), 0);
    chk("idle_halt_run", 32'(run), 0);

    do_run(1, 50, 1'b0, 0, 1'b0);

    // Auto-next sequence from a fresh reset, including the wrap.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    last_prog = 2;
    tick();
    for (int i = 0; i < 4; i++) do_run(3, 5 + i, 1'b0, 0, 1'b0);

    // Halt on the terminal-count cycle, stray start in RUN, long DONE hold.
    do_run(2, TMO, 1'b1, 10, 1'b1);
    // Hung program.
    do_run(0, 0, 1'b0, 2, 1'b0);

    for (int i = 0; i < 8; i++)
      do_run(int'($urandom_range(0, 3)), int'($urandom_range(1, 60)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)));

    // Reset in the middle of a run.
    bus.start = 1'b1;
    bus.start_sel = 2'd1;
    tick();
    bus.start = 1'b0;
    tick();
    repeat (37) tick();
    chk("mid_run_cycles", 32'(bus.cycles), 37);
    chk("mid_run_run", 32'(run), 1);
    #2 reset = 1'b0;
    #1 chk_reset_vals("mid_run_rst");
    tick();
    reset = 1'b1;
    last_prog = 2;
    tick();

    // Reset while in DONE: done drops with no ack.
    bus.start = 1'b1;
    bus.start_sel = 2'd2;
    tick();
    bus.start = 1'b0;
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("pre_rst_done", 32'(bus.done), 1);
    #2 reset = 1'b0;
    #1 chk_reset_vals("mid_done_rst");
    tick();
    reset = 1'b1;
    last_prog = 2;
    tick();

    do_run(3, 3, 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
